prod_accumulator: RTL and testbench

PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

---
 rtl/prod_accumulator.sv | 103 ++++++++++
 tb/tb_prod_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/prod_accumulator.sv
// Sums blocks of BLOCK_LEN unsigned 8-bit products, with valid/ready handshakes on both sides.
// Optional macro SATURATE_EN: clamp the accumulator at all-ones on overflow instead of wrapping.
module prod_accumulator #(
  parameter int BLOCK_LEN = 8,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             ovf,
  output logic [7:0]       cnt
);

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(BLOCK_LEN - 1);

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic               carry_seen_reg;
  logic [7:0]         cnt_reg;
  logic [ACC_W-1:0]   sum_reg;
  logic               ovf_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;

  logic [ACC_W:0]     add_full;
  logic               add_carry;
  logic [ACC_W-1:0]   acc_next;
  logic               carry_seen_next;
  logic               last_sample;

  // One extra bit on the adder exposes the carry out of the accumulator width.
  assign add_full  = {1'b0, acc_reg} + {{(ACC_W - 7){1'b0}}, prod};
  assign add_carry = add_full[ACC_W];

`ifdef SATURATE_EN
  // Once clamped, every further add carries again, so the value stays pinned at all-ones.
  assign acc_next = add_carry ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign acc_next = add_full[ACC_W-1:0];
`endif

  assign carry_seen_next = carry_seen_reg | add_carry;
  assign last_sample     = (cnt_reg == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_ACC;
      acc_reg        <= '0;
      carry_seen_reg <= 1'b0;
      cnt_reg        <= '0;
      sum_reg        <= '0;
      ovf_reg        <= 1'b0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
    end else if (state_reg == ST_ACC) begin
      if (clr) begin
        acc_reg        <= '0;
        carry_seen_reg <= 1'b0;
        cnt_reg        <= '0;
      end else if (in_valid) begin
        if (last_sample) begin
          sum_reg        <= acc_next;
          ovf_reg        <= carry_seen_next;
          acc_reg        <= '0;
          carry_seen_reg <= 1'b0;
          cnt_reg        <= '0;
          state_reg      <= ST_OUT;
          in_ready_reg   <= 1'b0;
          out_valid_reg  <= 1'b1;
        end else begin
          acc_reg        <= acc_next;
          carry_seen_reg <= carry_seen_next;
          cnt_reg        <= cnt_reg + 8'd1;
        end
      end
    end else begin
      // Result is held until consumed or aborted; no sample is taken on the release edge.
      if (clr || out_ready) begin
        state_reg     <= ST_ACC;
        in_ready_reg  <= 1'b1;
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign ovf       = ovf_reg;
  assign cnt       = cnt_reg;

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench for prod_accumulator: default instance plus an ACC_W=10 instance sharing stimulus.
module tb_prod_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, clr, out_ready;
  logic [7:0] prod;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [15:0] sum_a;
  logic [7:0]  cnt_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [9:0]  sum_b;
  logic [7:0]  cnt_b;

  prod_accumulator u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .prod(prod),
    .clr(clr), .out_valid(out_valid_a), .out_ready(out_ready), .sum(sum_a), .ovf(ovf_a),
    .cnt(cnt_a)
  );

  prod_accumulator #(.BLOCK_LEN(8), .ACC_W(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .prod(prod),
    .clr(clr), .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b), .ovf(ovf_b),
    .cnt(cnt_b)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: plain integer totals of accepted samples.
  int m_total = 0;
  int m_cnt   = 0;
  int m_res   = 0;
  bit m_out   = 1'b0;

  typedef struct {
    logic [7:0] p;
    int         e16;
    bit         o16;
    int         e10;
    bit         o10;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_sum(input int total, input int w);
    int lim;
    lim = (1 << w) - 1;
`ifdef SATURATE_EN
    return (total > lim) ? lim : total;
`else
    return total & lim;
`endif
  endfunction

  task automatic cycle(input bit v, input logic [7:0] p, input bit c, input bit r, input bit rn);
    in_valid  = v;
    prod      = p;
    clr       = c;
    out_ready = r;
    rst_n     = rn;
    @(posedge clk);
    if (!rn) begin
      m_total = 0; m_cnt = 0; m_out = 1'b0;
    end else if (c) begin
      if (m_out) m_out = 1'b0;
      else begin m_total = 0; m_cnt = 0; end
    end else if (m_out) begin
      if (r) m_out = 1'b0;
    end else if (v) begin
      m_total += int'(p);
      m_cnt++;
      if (m_cnt == 8) begin
        m_res = m_total; m_out = 1'b1; m_total = 0; m_cnt = 0;
      end
    end
    #1;
    check("out_valid16", 32'(out_valid_a), 32'(m_out));
    check("in_ready16", 32'(in_ready_a), 32'(!m_out));
    check("cnt16", 32'(cnt_a), 32'(m_cnt));
    check("out_valid10", 32'(out_valid_b), 32'(m_out));
    check("in_ready10", 32'(in_ready_b), 32'(!m_out));
    check("cnt10", 32'(cnt_b), 32'(m_cnt));
    if (m_out) begin
      check("sum16", 32'(sum_a), 32'(exp_sum(m_res, 16)));
      check("ovf16", 32'(ovf_a), 32'(m_res > 65535));
      check("sum10", 32'(sum_b), 32'(exp_sum(m_res, 10)));
      check("ovf10", 32'(ovf_b), 32'(m_res > 1023));
    end
    $display("cyc v=%0b p=%0d clr=%0b ordy=%0b rn=%0b | ov=%0b cnt=%0d sum16=%0d sum10=%0d",
             v, p, c, r, rn, out_valid_a, cnt_a, sum_a, sum_b);
  endtask

  initial begin
    int got;
    int guard;
    bit v;

    tbl[0] = '{p: 8'd225, e16: 1800, o16: 1'b0, e10: 776,  o10: 1'b1};
    tbl[1] = '{p: 8'd0,   e16: 0,    o16: 1'b0, e10: 0,    o10: 1'b0};
    tbl[2] = '{p: 8'd1,   e16: 8,    o16: 1'b0, e10: 8,    o10: 1'b0};
    tbl[3] = '{p: 8'd255, e16: 2040, o16: 1'b0, e10: 1016, o10: 1'b1};
    tbl[4] = '{p: 8'd10,  e16: 80,   o16: 1'b0, e10: 80,   o10: 1'b0};
    tbl[5] = '{p: 8'd128, e16: 1024, o16: 1'b0, e10: 0,    o10: 1'b1};
`ifdef SATURATE_EN
    tbl[0].e10 = 1023;
    tbl[3].e10 = 1023;
    tbl[5].e10 = 1023;
`endif

    // Reset state
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("rst_sum16", 32'(sum_a), 32'd0);
    check("rst_ovf16", 32'(ovf_a), 32'd0);
    check("rst_sum10", 32'(sum_b), 32'd0);
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    check("rst_in_ready", 32'(in_ready_a), 32'd1);

    // Table of full blocks of constant products, back-to-back, out_ready=1
    foreach (tbl[i]) begin
      for (int k = 0; k < 8; k++) cycle(1'b1, tbl[i].p, 1'b0, 1'b1, 1'b1);
      check("tbl_sum16", 32'(sum_a), 32'(tbl[i].e16));
      check("tbl_ovf16", 32'(ovf_a), 32'(tbl[i].o16));
      check("tbl_sum10", 32'(sum_b), 32'(tbl[i].e10));
      check("tbl_ovf10", 32'(ovf_b), 32'(tbl[i].o10));
      check("tbl_in_ready_out", 32'(in_ready_a), 32'd0);
      cycle(1'b1, tbl[i].p, 1'b0, 1'b1, 1'b1);
      check("tbl_out_valid_drop", 32'(out_valid_a), 32'd0);
      check("tbl_cnt_after_consume", 32'(cnt_a), 32'd0);
    end

    // Samples 1..8 with result held for 5 cycles
    for (int k = 1; k <= 8; k++) cycle(1'b1, 8'(k), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      check("hold_sum", 32'(sum_a), 32'd36);
      check("hold_in_ready", 32'(in_ready_a), 32'd0);
    end
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    check("hold_release", 32'(out_valid_a), 32'd0);

    // clr coinciding with the 4th transfer
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'd100, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 8'd100, 1'b1, 1'b1, 1'b1);
    check("clr_cnt", 32'(cnt_a), 32'd0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 8'd2, 1'b0, 1'b0, 1'b1);
    check("clr_sum", 32'(sum_a), 32'd16);
    cycle(1'b1, 8'd0, 1'b1, 1'b0, 1'b1);
    check("clr_in_out", 32'(out_valid_a), 32'd0);

    // Reset mid-block and during OUT
    for (int k = 0; k < 5; k++) cycle(1'b1, 8'd9, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    check("rstmid_cnt", 32'(cnt_a), 32'd0);
    check("rstmid_valid", 32'(out_valid_a), 32'd0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 8'd9, 1'b0, 1'b0, 1'b1);
    check("rstout_pre_sum", 32'(sum_a), 32'd72);
    cycle(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    check("rstout_valid", 32'(out_valid_a), 32'd0);
    check("rstout_sum16", 32'(sum_a), 32'd0);
    check("rstout_sum10", 32'(sum_b), 32'd0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 8'd7, 1'b0, 1'b0, 1'b1);
    check("rst_after_sum", 32'(sum_a), 32'd56);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    // Random in_valid gaps with prod=10
    got = 0;
    guard = 0;
    while (got < 8 && guard < 1000) begin
      v = 1'($urandom_range(0, 1));
      cycle(v, 8'd10, 1'b0, 1'b0, 1'b1);
      if (v) got++;
      guard++;
    end
    check("gap_done", 32'(got), 32'd8);
    check("gap_sum", 32'(sum_a), 32'd80);
    cycle(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 199) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
